// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit in front of a word-addressed
// data memory. Byte/half/word loads are extracted, extended and registered.
// Byte/half stores run as a two-cycle read-modify-write with a one-cycle stall.
//
// Optional feature macro: LSU_ALIGN_CHECK_EN
//   defined   - misaligned requests are rejected and reported on misalign
//   undefined - misalign tied low, size 11 acts as word, offending low
//               address bits are masked and the access proceeds
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   req_valid/we/size/unsigned/addr/wdata   request from EX/MEM
//   busy                  combinational pipeline stall
//   resp_valid/rdata      registered completion pulse and load result
//   misalign              registered, qualified by resp_valid
//   mem_addr/read/write/wdata/rdata         word memory interface
module mem_access_unit #(
    parameter int          ADDR_W      = 32,
    parameter logic [31:0] RESET_RDATA = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    state_t state, state_n;

    // Merge buffer for sub-word stores
    logic [31:0]       lat_word;
    logic [ADDR_W-3:0] lat_waddr;
    logic [1:0]        lat_off;
    logic              lat_half;
    logic [31:0]       lat_wdata;

    logic [1:0]  eff_size;
    logic [1:0]  off;
    logic        mis_req;
    logic [31:0] rd_sh;
    logic [31:0] load_val;
    logic [31:0] lane_mask;
    logic [31:0] wd_sh;
    logic [31:0] merged;

    // Request decode: effective size, lane offset and alignment
    always_comb begin
`ifdef LSU_ALIGN_CHECK_EN
        eff_size = req_size;
        off      = req_addr[1:0];
        mis_req  = (req_size == 2'b11)
                 || (req_size == SZ_H && req_addr[0])
                 || (req_size == SZ_W && req_addr[1:0] != 2'b00);
`else
        eff_size = (req_size == 2'b11) ? SZ_W : req_size;
        mis_req  = 1'b0;
        if (eff_size == SZ_B)
            off = req_addr[1:0];
        else if (eff_size == SZ_H)
            off = {req_addr[1], 1'b0};
        else
            off = 2'b00;
`endif
    end

    // Load lane extraction and extension
    always_comb begin
        rd_sh = mem_rdata >> {off, 3'b000};
        if (eff_size == SZ_B)
            load_val = {{24{~req_unsigned & rd_sh[7]}}, rd_sh[7:0]};
        else if (eff_size == SZ_H)
            load_val = {{16{~req_unsigned & rd_sh[15]}}, rd_sh[15:0]};
        else
            load_val = mem_rdata;
    end

    // Store merge: replace only the addressed lane of the latched word
    always_comb begin
        lane_mask = (lat_half ? 32'h0000_FFFF : 32'h0000_00FF)
                    << {lat_off, 3'b000};
        wd_sh     = lat_wdata << {lat_off, 3'b000};
        merged    = (lat_word & ~lane_mask) | (wd_sh & lane_mask);
    end

    // Next state and memory strobes
    always_comb begin
        state_n   = state;
        busy      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = {req_addr[ADDR_W-1:2], 2'b00};
        mem_wdata = req_wdata;
        unique case (state)
            IDLE: begin
                if (req_valid && !mis_req) begin
                    if (!req_we) begin
                        mem_read = 1'b1;
                    end else if (eff_size == SZ_W) begin
                        mem_write = 1'b1;
                    end else begin
                        mem_read = 1'b1;
                        busy     = 1'b1;
                        state_n  = MERGE;
                    end
                end
            end
            MERGE: begin
                mem_addr  = {lat_waddr, 2'b00};
                mem_wdata = merged;
                mem_write = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Reset overrides everything, including a pending merge write
        if (rst) begin
            busy      = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            state_n   = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            misalign   <= 1'b0;
            resp_rdata <= RESET_RDATA;
            lat_word   <= '0;
            lat_waddr  <= '0;
            lat_off    <= '0;
            lat_half   <= 1'b0;
            lat_wdata  <= '0;
        end else begin
            state      <= state_n;
            resp_valid <= 1'b0;
            misalign   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (mis_req) begin
                            resp_valid <= 1'b1;
                            misalign   <= 1'b1;
                            resp_rdata <= RESET_RDATA;
                        end else if (!req_we) begin
                            resp_valid <= 1'b1;
                            resp_rdata <= load_val;
                        end else if (eff_size == SZ_W) begin
                            resp_valid <= 1'b1;
                        end else begin
                            lat_word  <= mem_rdata;
                            lat_waddr <= req_addr[ADDR_W-1:2];
                            lat_off   <= off;
                            lat_half  <= (eff_size == SZ_H);
                            lat_wdata <= req_wdata;
                        end
                    end
                end
                MERGE: begin
                    resp_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit directly upstream of the word-addressed data memory in the pipelined CPU's MEM stage.
- Accepts byte, halfword and word requests from the EX/MEM register and drives the memory's word interface (addr, MemRead, MemWrite, din, dmread).
- Sub-word stores run as a two-cycle read-modify-write, stalling the pipeline for one cycle.
- Sub-word loads are lane-extracted and sign- or zero-extended into a registered response for MEM/WB.

Parameters:
- ADDR_W, 32, request/memory address width.
- RESET_RDATA, 32'h0, value loaded into resp_rdata on reset and on a misaligned response.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset (see Behaviour)
- req_valid  in  1  request present this cycle; held stable by the requester while busy=1
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- busy  out  1  pipeline stall request, combinational
- resp_valid  out  1  registered one-cycle completion pulse
- resp_rdata  out  32  registered load result
- misalign  out  1  registered, qualified by resp_valid
- mem_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, combinational from mem_addr

Behaviour:
- Reset rst is synchronous and active-high.
  - Registered state at the edge: state=IDLE, resp_valid=0, misalign=0, resp_rdata=RESET_RDATA, merge buffer=0.
  - While rst=1, busy, mem_read and mem_write are forced to 0, overriding every state.
- Byte order is little-endian: byte offset k occupies bits [8k+7:8k]; halfword offset 2 occupies bits [31:16].
- Alignment rules: a half requires addr[0]=0; a word requires addr[1:0]=00; size 11 is always misaligned.
- State IDLE, with req_valid=1:
  - Misaligned request: no memory strobes. Next edge: resp_valid=1, misalign=1, resp_rdata=RESET_RDATA.
  - Load: mem_read=1 in the same cycle. At the edge, resp_rdata captures the extracted and extended lane and resp_valid=1. Latency is 1 cycle and busy stays 0.
  - Word store: mem_write=1 and mem_wdata=req_wdata in the same cycle. resp_valid=1 next cycle; busy stays 0.
  - Byte or half store: mem_read=1 and busy=1. At the edge, latch mem_rdata, addr, size and wdata into the merge buffer, then go to MERGE.
- State IDLE, with req_valid=0: all strobes 0, busy=0; resp_valid deasserts next edge.
- State MERGE:
  - mem_addr comes from the latched address.
  - mem_write=1 with mem_wdata = latched word, with only the addressed lane replaced by the low byte/half of the latched wdata.
  - busy=0; req_* inputs are ignored.
  - Next edge: resp_valid=1, misalign=0, state=IDLE.
  - A new request is accepted only in IDLE. Back-to-back sub-word stores cost 2 cycles each.
- When resp_valid=1, resp_rdata holds the load result. For stores it holds its previous value.
- mem_addr, mem_wdata and the strobes are stable for the whole cycle in which a strobe is high. No strobe is asserted without req_valid=1 or state=MERGE.
- Reset mid-operation: rst=1 in MERGE suppresses that cycle's write and returns to IDLE with resp_valid=0. The merged store is lost, and the pipeline flushes it.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN
- Defined: alignment rules above are enforced and misalign is reported.
- Undefined:
  - misalign is tied to 0 and size 11 is treated as word.
  - Offending low address bits are masked (half ignores addr[0]; word ignores addr[1:0]) and the access proceeds normally.

Test Plan:
- Store word: sw addr 0x10, data 0xDEADBEEF. Required: same cycle mem_write=1, mem_addr=0x10, mem_wdata=0xDEADBEEF, busy=0; next cycle resp_valid=1.
- Load byte: addr 0x13 with mem_rdata=0x80FF1234. lb gives resp_rdata 0xFFFFFF80 one cycle later; lbu gives 0x00000080.
- Store byte: sb addr 0x11, data 0xAA, mem_rdata=0x11223344.
  - Cycle0: busy=1, mem_read=1.
  - Cycle1: mem_write=1, mem_wdata=0x1122AA44, busy=0.
  - Cycle2: resp_valid=1.
- Store then load half: sh addr 0x12, data 0xBEEF over 0x11223344 gives mem_wdata 0xBEEF3344. Then lh 0x12 reading 0xBEEF3344 gives resp_rdata 0xFFFFBEEF.
- Misaligned word load: lw addr 0x06.
  - Macro on: mem_read=0, next cycle resp_valid=1, misalign=1, resp_rdata=0.
  - Macro off: mem_read=1, mem_addr=0x04, misalign=0.
- Reset during MERGE: sb issued, rst=1 in cycle1. Required: mem_write=0 and busy=0 that cycle; after the edge state=IDLE, resp_valid=0, resp_rdata=0.
